// File: rtl/commit_monitor_pkg.sv
// Shared defaults, watchdog state type and popcount helper for the commit progress monitor.
package commit_monitor_pkg;

    localparam int unsigned DEF_COMMIT_WIDTH = 6;
    localparam int unsigned DEF_CNT_W        = 64;
    localparam int unsigned DEF_DROP_W       = 16;
    localparam int unsigned MAX_COMMIT_WIDTH = 64;
    localparam int unsigned POP_W            = 7;

    typedef enum logic {
        RUN   = 1'b0,
        STUCK = 1'b1
    } wd_state_e;

    // Callers zero-extend their commit vector to MAX_COMMIT_WIDTH.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_COMMIT_WIDTH-1:0] i_bits);
        logic [POP_W-1:0] w_sum;
        w_sum = '0;
        for (int i = 0; i < MAX_COMMIT_WIDTH; i++) begin
            w_sum = w_sum + POP_W'(i_bits[i]);
        end
        return w_sum;
    endfunction

endpackage

// File: rtl/commit_monitor_report_buf.sv
// Single-entry snapshot buffer with valid/ready output, drop detection and a saturating
// dropped-snapshot counter.
module commit_monitor_report_buf
    import commit_monitor_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned DROP_W = DEF_DROP_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_trigger,
    input  logic [CNT_W-1:0]  i_cycle,
    input  logic [CNT_W-1:0]  i_instr,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_cycle,
    output logic [CNT_W-1:0]  o_instr,
    output logic [DROP_W-1:0] o_dropped
);

    logic              r_valid;
    logic [CNT_W-1:0]  r_cycle;
    logic [CNT_W-1:0]  r_instr;
    logic [DROP_W-1:0] r_dropped;
    logic              w_load;
    logic              w_drop;

    // A full buffer can still take a new snapshot if the old one leaves this cycle.
    always_comb begin
        w_load = i_trigger && (!r_valid || i_ready);
        w_drop = i_trigger && r_valid && !i_ready;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_cycle   <= '0;
            r_instr   <= '0;
            r_dropped <= '0;
        end else if (i_clear) begin
            r_valid   <= 1'b0;
            r_cycle   <= '0;
            r_instr   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_cycle <= i_cycle;
                r_instr <= i_instr;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop && (r_dropped != '1)) begin
                r_dropped <= r_dropped + DROP_W'(1);
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_cycle   = r_cycle;
    assign o_instr   = r_instr;
    assign o_dropped = r_dropped;

endmodule

// File: rtl/commit_monitor.sv
// Commit progress monitor: cycle/instruction counters, no-commit watchdog and periodic
// progress snapshots delivered through a single-entry valid/ready buffer.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH  = DEF_COMMIT_WIDTH,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STUCK_LIMIT   = 5000,
    parameter int unsigned REPORT_PERIOD = 10000,
    parameter int unsigned DROP_W        = DEF_DROP_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic                    commit_is_walk,
    input  logic                    clear,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [CNT_W-1:0]        report_cycle,
    output logic [CNT_W-1:0]        report_instr,
    output logic [DROP_W-1:0]       report_dropped,
    output logic                    stuck,
    output logic                    stuck_fire,
    output logic [CNT_W-1:0]        stuck_cycle
);

    localparam int unsigned TIMER_W = $clog2(STUCK_LIMIT + 2);
    localparam int unsigned PER_W   = $clog2(REPORT_PERIOD);
    localparam logic [TIMER_W-1:0] TIMER_SAT = TIMER_W'(STUCK_LIMIT + 1);
    localparam logic [PER_W-1:0]   PER_LAST  = PER_W'(REPORT_PERIOD - 1);

    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_instr_cnt;
    logic [TIMER_W-1:0] r_timer;
    logic [PER_W-1:0]   r_period;
    logic               r_stuck_fire;
    logic [CNT_W-1:0]   r_stuck_cycle;
    wd_state_e          r_state;
    wd_state_e          w_state_next;
    logic               w_fire;
    logic               w_has_commit;
    logic               w_trigger;
    logic [POP_W-1:0]   w_pop;

    always_comb begin
        w_has_commit = !commit_is_walk && commit_valid[0];
        w_trigger    = (r_period == '0);
        w_pop        = popcount(MAX_COMMIT_WIDTH'(commit_valid));
    end

    // The timer saturates at STUCK_LIMIT+1, so "exceeds the limit" is an equality test.
    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        unique case (r_state)
            RUN: begin
                if ((r_timer == TIMER_SAT) && !w_has_commit) begin
                    w_state_next = STUCK;
                    w_fire       = 1'b1;
                end
            end
            STUCK:   w_state_next = STUCK;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else if (clear) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt   <= '0;
            r_instr_cnt   <= '0;
            r_timer       <= '0;
            r_period      <= '0;
            r_stuck_fire  <= 1'b0;
            r_stuck_cycle <= '0;
        end else if (clear) begin
            r_cycle_cnt   <= '0;
            r_instr_cnt   <= '0;
            r_timer       <= '0;
            r_period      <= '0;
            r_stuck_fire  <= 1'b0;
            r_stuck_cycle <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (!commit_is_walk) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(w_pop);
            end
            if (w_has_commit) begin
                r_timer <= '0;
            end else if (r_timer != TIMER_SAT) begin
                r_timer <= r_timer + TIMER_W'(1);
            end
            r_period     <= (r_period == PER_LAST) ? '0 : r_period + PER_W'(1);
            r_stuck_fire <= w_fire;
            if (w_fire) begin
                r_stuck_cycle <= r_cycle_cnt;
            end
        end
    end

    commit_monitor_report_buf #(
        .CNT_W  (CNT_W),
        .DROP_W (DROP_W)
    ) u_report_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clear   (clear),
        .i_trigger (w_trigger),
        .i_cycle   (r_cycle_cnt),
        .i_instr   (r_instr_cnt),
        .i_ready   (report_ready),
        .o_valid   (report_valid),
        .o_cycle   (report_cycle),
        .o_instr   (report_instr),
        .o_dropped (report_dropped)
    );

    assign stuck       = (r_state == STUCK);
    assign stuck_fire  = r_stuck_fire;
    assign stuck_cycle = r_stuck_cycle;

endmodule

// File: tb/tb_commit_monitor.sv
// Randomized and directed bench for commit_monitor with a scoreboard fed by a behavioural model.
module tb_commit_monitor;

    localparam int unsigned CW     = 6;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned LIMIT  = 8;
    localparam int unsigned PERIOD = 16;
    localparam int unsigned DROP_W = 2;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [CW-1:0]     commit_valid = '0;
    logic              commit_is_walk = 1'b0;
    logic              clear = 1'b0;
    logic              report_ready = 1'b0;
    logic              report_valid;
    logic [CNT_W-1:0]  report_cycle;
    logic [CNT_W-1:0]  report_instr;
    logic [DROP_W-1:0] report_dropped;
    logic              stuck;
    logic              stuck_fire;
    logic [CNT_W-1:0]  stuck_cycle;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    commit_monitor #(
        .COMMIT_WIDTH  (CW),
        .CNT_W         (CNT_W),
        .STUCK_LIMIT   (LIMIT),
        .REPORT_PERIOD (PERIOD),
        .DROP_W        (DROP_W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .commit_valid   (commit_valid),
        .commit_is_walk (commit_is_walk),
        .clear          (clear),
        .report_valid   (report_valid),
        .report_ready   (report_ready),
        .report_cycle   (report_cycle),
        .report_instr   (report_instr),
        .report_dropped (report_dropped),
        .stuck          (stuck),
        .stuck_fire     (stuck_fire),
        .stuck_cycle    (stuck_cycle)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts since reset/clear, consecutive idle cycles, expected snapshots.
    typedef struct {
        longint unsigned cyc;
        longint unsigned ins;
    } snap_t;

    snap_t           exp_q[$];
    longint unsigned m_cycle = 0;
    longint unsigned m_instr = 0;
    longint unsigned m_idle = 0;
    longint unsigned m_stuck_cycle = 0;
    int unsigned     m_dropped = 0;
    bit              m_full = 1'b0;
    bit              m_stuck = 1'b0;
    bit              m_fire = 1'b0;
    bit              m_has;
    bit              m_trig;

    function automatic void reset_model();
        m_cycle       = 0;
        m_instr       = 0;
        m_idle        = 0;
        m_stuck_cycle = 0;
        m_dropped     = 0;
        m_full        = 1'b0;
        m_stuck       = 1'b0;
        m_fire        = 1'b0;
        exp_q.delete();
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n || clear) begin
            reset_model();
        end else begin
            m_has  = !commit_is_walk && commit_valid[0];
            m_trig = (m_cycle % PERIOD) == 0;
            if (m_trig) begin
                if (!m_full || report_ready) begin
                    exp_q.push_back('{m_cycle, m_instr});
                    m_full = 1'b1;
                end else if (m_dropped < DROP_MAX) begin
                    m_dropped++;
                end
            end else if (report_ready) begin
                m_full = 1'b0;
            end
            m_fire = 1'b0;
            if (!m_stuck && !m_has && m_idle > LIMIT) begin
                m_stuck       = 1'b1;
                m_fire        = 1'b1;
                m_stuck_cycle = m_cycle;
            end
            m_idle = m_has ? 0 : m_idle + 1;
            m_cycle++;
            if (!commit_is_walk) m_instr += $countones(commit_valid);
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            check("report_valid", report_valid, m_full);
            if (m_full) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: report presented, expected queue empty at %0t", $time);
                end else begin
                    check("report_cycle", report_cycle, exp_q[0].cyc);
                    check("report_instr", report_instr, exp_q[0].ins);
                    if (report_ready) void'(exp_q.pop_front());
                end
            end
            check("report_dropped", report_dropped, m_dropped);
            check("stuck", stuck, m_stuck);
            check("stuck_fire", stuck_fire, m_fire);
            check("stuck_cycle", stuck_cycle, m_stuck_cycle);
        end
    end

    task automatic run(input int n, input logic [CW-1:0] v, input logic w, input logic r);
        commit_valid   = v;
        commit_is_walk = w;
        report_ready   = r;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_clear(input logic r);
        commit_valid   = '0;
        commit_is_walk = 1'b0;
        report_ready   = r;
        clear          = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #23;
        check("rst_valid", report_valid, 0);
        check("rst_dropped", report_dropped, 0);
        check("rst_stuck", stuck, 0);
        check("rst_stuck_fire", stuck_fire, 0);
        check("rst_stuck_cycle", stuck_cycle, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Idle after reset: snapshots every period, watchdog fires with cycle 9.
        run(40, '0, 1'b0, 1'b1);
        check("idle_stuck", stuck, 1);
        check("idle_stuck_cycle", stuck_cycle, 9);

        pulse_clear(1'b1);
        run(17, 6'b111111, 1'b0, 1'b1);
        check("full_snap_cycle", report_cycle, 16);
        check("full_snap_instr", report_instr, 96);
        run(3, 6'b111111, 1'b0, 1'b1);

        pulse_clear(1'b1);
        run(17, 6'b111111, 1'b1, 1'b1);
        check("walk_snap_instr", report_instr, 0);
        run(3, 6'b111111, 1'b1, 1'b1);

        pulse_clear(1'b1);
        run(17, 6'b111110, 1'b0, 1'b1);
        check("noslot0_snap_instr", report_instr, 80);
        check("noslot0_stuck", stuck, 1);
        run(3, 6'b111110, 1'b0, 1'b1);

        // Backpressure across three triggers, then release.
        pulse_clear(1'b0);
        run(34, '0, 1'b0, 1'b0);
        check("bp_dropped", report_dropped, 2);
        check("bp_valid", report_valid, 1);
        check("bp_cycle", report_cycle, 0);
        run(1, '0, 1'b0, 1'b1);
        check("bp_drained", report_valid, 0);

        pulse_clear(1'b0);
        run(6 * PERIOD + 2, '0, 1'b0, 1'b0);
        check("drop_saturated", report_dropped, DROP_MAX);

        // Stuck, commits resume, then clear.
        pulse_clear(1'b1);
        run(15, '0, 1'b0, 1'b1);
        run(10, 6'b000111, 1'b0, 1'b1);
        check("sticky_stuck", stuck, 1);
        pulse_clear(1'b1);
        check("clr_valid", report_valid, 0);
        check("clr_cycle", report_cycle, 0);
        check("clr_instr", report_instr, 0);
        check("clr_stuck", stuck, 0);
        check("clr_stuck_cycle", stuck_cycle, 0);
        run(1, '0, 1'b0, 1'b0);
        check("clr_first_valid", report_valid, 1);
        check("clr_first_cycle", report_cycle, 0);

        // Randomized segments with varying commit density.
        for (int seg = 0; seg < 60; seg++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 40; c++) begin
                logic [CW-1:0] v;
                v = CW'($urandom);
                if (mode == 0) v[0] = 1'b0;
                if (mode == 2) v[0] = 1'b1;
                clear = ($urandom_range(0, 199) == 0);
                run(1, v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6));
            end
        end
        clear = 1'b0;

        // Reset mid-period with a pending snapshot.
        pulse_clear(1'b0);
        run(5, 6'b000001, 1'b0, 1'b0);
        check("pre_rst_valid", report_valid, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", report_valid, 0);
        check("async_rst_dropped", report_dropped, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run(20, 6'b000011, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
